// File: rtl/montgomery_exp_pkg.sv
// Shared types and defaults for the Montgomery exponentiation slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package montgomery_exp_pkg;

    localparam int DEF_WIDTH = 1024;
    localparam int DEF_EBITS = 1024;

    typedef enum logic [2:0] {
        IDLE,
        SQ_START,
        SQ_WAIT,
        MUL_START,
        MUL_WAIT,
        FINISH
    } exp_state_t;

    // Width of a bit index that can address every exponent bit.
    function automatic int idx_bits(input int ebits);
        return (ebits > 1) ? $clog2(ebits) : 1;
    endfunction

endpackage

// File: rtl/montgomery_exp_if.sv
// Request bus plus external multiplier handshake for montgomery_exp.
// Latency: n/a (wiring only).
// Backpressure: start is taken only when the engine is idle; mm_done paces the multiplier.
interface montgomery_exp_if #(
    parameter int WIDTH = montgomery_exp_pkg::DEF_WIDTH,
    parameter int EBITS = montgomery_exp_pkg::DEF_EBITS
);
    logic             start;
    logic [WIDTH-1:0] in_x;
    logic [EBITS-1:0] in_e;
    logic [WIDTH-1:0] in_m;
    logic [WIDTH-1:0] in_r;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             mm_start;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_m;
    logic [WIDTH-1:0] mm_result;
    logic             mm_done;

    // The exponentiation engine.
    modport slave (
        input  start, in_x, in_e, in_m, in_r, mm_result, mm_done,
        output result, done, mm_start, mm_a, mm_b, mm_m
    );

    // The requester together with the multiplier it pairs the engine with.
    modport master (
        output start, in_x, in_e, in_m, in_r, mm_result, mm_done,
        input  result, done, mm_start, mm_a, mm_b, mm_m
    );
endinterface

// File: rtl/montgomery_exp.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Latency: EBITS + popcount(e) multiplications, done 2 cycles after the last mm_done.
// Backpressure: start ignored unless idle; each step waits indefinitely for mm_done.
module montgomery_exp
    import montgomery_exp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int EBITS = DEF_EBITS
) (
    input  logic            clk,
    input  logic            reset,
    montgomery_exp_if.slave bus
);
    localparam int IW = idx_bits(EBITS);

    exp_state_t       state;
    exp_state_t       state_n;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] m_q;
    logic [EBITS-1:0] e_q;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] result_q;
    logic             done_q;
    logic             accept;
    logic             take_mm;
    logic             step;
    logic             mm_start_c;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-state strobes; mm_done only counts in the two wait states.
    always_comb begin
        state_n    = state;
        mm_start_c = 1'b0;
        accept     = 1'b0;
        take_mm    = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_n = SQ_START;
                end
            end
            SQ_START: begin
                mm_start_c = 1'b1;
                state_n    = SQ_WAIT;
            end
            SQ_WAIT: begin
                if (bus.mm_done) begin
                    take_mm = 1'b1;
                    if (e_q[idx]) begin
                        state_n = MUL_START;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            MUL_START: begin
                mm_start_c = 1'b1;
                state_n    = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (bus.mm_done) begin
                    take_mm = 1'b1;
                    step    = 1'b1;
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (step) begin
            state_n = (idx == '0) ? FINISH : SQ_START;
        end
    end

    // Operand capture, accumulator update, bit index walk and result hand-off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            x_q      <= '0;
            m_q      <= '0;
            e_q      <= '0;
            idx      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            if (accept) begin
                x_q <= bus.in_x;
                e_q <= bus.in_e;
                m_q <= bus.in_m;
                acc <= bus.in_r;
                idx <= IW'(EBITS - 1);
            end
            if (take_mm) begin
                acc <= bus.mm_result;
            end
            if (step && (idx != '0)) begin
                idx <= idx - 1'b1;
            end
            done_q <= (state == FINISH);
            if (state == FINISH) begin
                result_q <= acc;
            end
        end
    end

    // Operands come straight from registers that hold still while a multiply is in flight.
    assign bus.mm_start = mm_start_c;
    assign bus.mm_a     = acc;
    assign bus.mm_b     = ((state == MUL_START) || (state == MUL_WAIT)) ? x_q : acc;
    assign bus.mm_m     = m_q;
    assign bus.result   = result_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_montgomery_exp.sv
// Randomised bench for montgomery_exp with a 5-cycle behavioural Montgomery multiplier.
// Latency: n/a.
// Backpressure: n/a.
module tb_montgomery_exp;
    localparam int W  = 16;
    localparam int EB = 8;

    logic clk = 1'b0;
    logic reset;

    montgomery_exp_if #(.WIDTH(W), .EBITS(EB)) bus ();

    montgomery_exp #(.WIDTH(W), .EBITS(EB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observation state written only by the multiplier model below.
    int          pulses   = 0;
    int          dones    = 0;
    int          nonsq    = 0;
    int          stab_err = 0;
    int          fires    = 0;
    int          cyc      = 0;
    int          fire_cyc = 0;
    int          done_cyc = 0;
    int          cnt      = 0;
    bit          busy     = 1'b0;
    bit          chk      = 1'b0;
    logic [15:0] cap_a, cap_b, cap_m, last_b;
    logic [15:0] exp_m = 16'd0;

    // a*b*2^-16 mod m, by repeated halving.
    function automatic logic [15:0] ref_mm(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] m);
        longint t;
        if (m == 16'd0) return 16'd0;
        t = longint'(a) * longint'(b);
        for (int i = 0; i < 16; i++) begin
            if (t[0]) t = t + longint'(m);
            t = t >> 1;
        end
        return 16'(t % longint'(m));
    endfunction

    function automatic logic [15:0] to_mont(input logic [15:0] v, input logic [15:0] m);
        return 16'((longint'(v) << 16) % longint'(m));
    endfunction

    // Plain right-to-left modular power of the base, converted to Montgomery form.
    function automatic logic [15:0] ref_exp(input logic [15:0] xp, input logic [7:0] e,
                                            input logic [15:0] m);
        longint r, b;
        r = 1 % longint'(m);
        b = longint'(xp) % longint'(m);
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = (r * b) % longint'(m);
            b = (b * b) % longint'(m);
        end
        return to_mont(16'(r), m);
    endfunction

    // Multiplier model and observer, evaluated away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (reset) chk = 1'b0;
        if (bus.mm_done === 1'b1) busy = 1'b0;
        bus.mm_done   = 1'b0;
        bus.mm_result = 16'd0;
        if (busy) begin
            if (chk && (bus.mm_a !== cap_a || bus.mm_b !== cap_b || bus.mm_m !== cap_m))
                stab_err++;
            cnt--;
            if (cnt == 0) begin
                bus.mm_result = ref_mm(cap_a, cap_b, cap_m);
                bus.mm_done   = 1'b1;
                fire_cyc      = cyc;
                fires++;
            end
        end
        if (bus.mm_start === 1'b1) begin
            pulses++;
            if (bus.mm_a !== bus.mm_b) nonsq++;
            if (bus.mm_m !== exp_m) stab_err++;
            cap_a  = bus.mm_a;
            cap_b  = bus.mm_b;
            cap_m  = bus.mm_m;
            last_b = bus.mm_b;
            busy   = 1'b1;
            chk    = 1'b1;
            cnt    = 5;
        end
        if (bus.done === 1'b1) begin
            dones++;
            done_cyc = cyc;
        end
    end

    task automatic launch(input logic [15:0] x, input logic [7:0] e,
                          input logic [15:0] m, input logic [15:0] r);
        @(negedge clk);
        bus.in_x  = x;
        bus.in_e  = e;
        bus.in_m  = m;
        bus.in_r  = r;
        exp_m     = m;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit to);
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (dones > d0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [15:0] x, input logic [7:0] e, input logic [15:0] m,
                          input logic [15:0] r, output int np, output int nd, output bit to);
        int p0, d0;
        p0 = pulses;
        d0 = dones;
        launch(x, e, m, r);
        wait_done(d0, to);
        repeat (3) @(negedge clk);
        #1;
        np = pulses - p0;
        nd = dones - d0;
    endtask

    function automatic logic [15:0] rand_mod();
        return 16'($urandom_range(3, 32767)) | 16'd1;
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.in_x  = '0;
        bus.in_e  = '0;
        bus.in_m  = '0;
        bus.in_r  = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.mm_start !== 1'b0) begin errors++; $display("FAIL reset_mm_start got %b want 0", bus.mm_start); end
        checks++; if (bus.result !== 16'd0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
        checks++; if (bus.mm_a !== 16'd0 || bus.mm_b !== 16'd0 || bus.mm_m !== 16'd0) begin
            errors++; $display("FAIL reset_operands got a=%h b=%h m=%h want 0", bus.mm_a, bus.mm_b, bus.mm_m);
        end
        reset = 1'b0;
    endtask

    task automatic test_e_zero();
        logic [15:0] m, xp, x, r;
        int np, nd, s0, q0;
        bit to;
        m = rand_mod(); xp = 16'($urandom_range(0, m - 1)); x = to_mont(xp, m); r = to_mont(16'd1, m);
        s0 = stab_err; q0 = nonsq;
        run_op(x, 8'h00, m, r, np, nd, to);
        checks++; if (to) begin errors++; $display("FAIL e0_timeout got no done want done"); end
        checks++; if (np != 8) begin errors++; $display("FAIL e0_pulses got %0d want 8", np); end
        checks++; if (nonsq != q0) begin errors++; $display("FAIL e0_all_squares got %0d non-square want 0", nonsq - q0); end
        checks++; if (bus.result !== r) begin errors++; $display("FAIL e0_result got %h want %h", bus.result, r); end
        checks++; if (nd != 1) begin errors++; $display("FAIL e0_done_count got %0d want 1", nd); end
        checks++; if (stab_err != s0) begin errors++; $display("FAIL e0_operand_stability got %0d want 0", stab_err - s0); end
    endtask

    task automatic test_e_one();
        logic [15:0] m, xp, x, r;
        int np, nd;
        bit to;
        m = rand_mod(); xp = 16'($urandom_range(1, m - 1)); x = to_mont(xp, m); r = to_mont(16'd1, m);
        run_op(x, 8'h01, m, r, np, nd, to);
        checks++; if (to) begin errors++; $display("FAIL e1_timeout got no done want done"); end
        checks++; if (np != 9) begin errors++; $display("FAIL e1_pulses got %0d want 9", np); end
        checks++; if (last_b !== x) begin errors++; $display("FAIL e1_last_mm_b got %h want %h", last_b, x); end
        checks++; if (bus.result !== x) begin errors++; $display("FAIL e1_result got %h want %h", bus.result, x); end
    endtask

    task automatic test_all_ones();
        logic [15:0] m, xp, x, r, want;
        int np, nd;
        bit to;
        m = 16'd13; xp = 16'($urandom_range(2, 12)); x = to_mont(xp, m); r = to_mont(16'd1, m);
        want = ref_exp(xp, 8'hFF, m);
        run_op(x, 8'hFF, m, r, np, nd, to);
        checks++; if (to) begin errors++; $display("FAIL eff_timeout got no done want done"); end
        checks++; if (np != 16) begin errors++; $display("FAIL eff_pulses got %0d want 16", np); end
        checks++; if (bus.result !== want) begin errors++; $display("FAIL eff_result got %h want %h", bus.result, want); end
    endtask

    task automatic test_random();
        logic [15:0] m, xp, x, r, want;
        logic [7:0]  e;
        int np, nd, s0;
        bit to;
        for (int k = 0; k < 6; k++) begin
            m = rand_mod(); xp = 16'($urandom_range(0, m - 1)); e = 8'($urandom);
            x = to_mont(xp, m); r = to_mont(16'd1, m); want = ref_exp(xp, e, m);
            s0 = stab_err;
            run_op(x, e, m, r, np, nd, to);
            checks++; if (to) begin errors++; $display("FAIL rnd%0d_timeout got no done want done", k); end
            checks++; if (np != 8 + $countones(e)) begin errors++; $display("FAIL rnd%0d_pulses got %0d want %0d", k, np, 8 + $countones(e)); end
            checks++; if (bus.result !== want) begin errors++; $display("FAIL rnd%0d_result e=%h m=%h got %h want %h", k, e, m, bus.result, want); end
            checks++; if (nd != 1) begin errors++; $display("FAIL rnd%0d_done_count got %0d want 1", k, nd); end
            checks++; if (done_cyc - fire_cyc != 2) begin errors++; $display("FAIL rnd%0d_latency got %0d want 2", k, done_cyc - fire_cyc); end
            checks++; if (stab_err != s0) begin errors++; $display("FAIL rnd%0d_operand_stability got %0d want 0", k, stab_err - s0); end
        end
    endtask

    task automatic test_ignore_start();
        logic [15:0] m, xp, x, r, want;
        logic [7:0]  e;
        int p0, d0, s0;
        bit to;
        m = rand_mod(); xp = 16'($urandom_range(0, m - 1)); e = 8'($urandom) | 8'h81;
        x = to_mont(xp, m); r = to_mont(16'd1, m); want = ref_exp(xp, e, m);
        p0 = pulses; d0 = dones; s0 = stab_err;
        launch(x, e, m, r);
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_x  = ~x;
        bus.in_e  = ~e;
        bus.in_m  = m ^ 16'h0F0E;
        bus.in_r  = ~r;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_x  = x + 16'd1;
        wait_done(d0, to);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (to) begin errors++; $display("FAIL ign_timeout got no done want done"); end
        checks++; if (bus.result !== want) begin errors++; $display("FAIL ign_result got %h want %h", bus.result, want); end
        checks++; if (pulses - p0 != 8 + $countones(e)) begin errors++; $display("FAIL ign_pulses got %0d want %0d", pulses - p0, 8 + $countones(e)); end
        checks++; if (dones - d0 != 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", dones - d0); end
        checks++; if (stab_err != s0) begin errors++; $display("FAIL ign_operand_stability got %0d want 0", stab_err - s0); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] m, xp, x, r;
        int p0, d0, f0;
        bit seen;
        m = rand_mod(); xp = 16'($urandom_range(1, m - 1)); x = to_mont(xp, m); r = to_mont(16'd1, m);
        p0 = pulses; d0 = dones;
        launch(x, 8'h80, m, r);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (pulses >= p0 + 2) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstmid_mul_pulse got %0d pulses want %0d", pulses - p0, 2); end
        @(posedge clk);
        #1;
        f0 = fires;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        checks++; if (fires <= f0) begin errors++; $display("FAIL rstmid_late_mm_done got %0d want >0", fires - f0); end
        checks++; if (dones != d0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", dones - d0); end
        checks++; if (bus.result !== 16'd0 || bus.done !== 1'b0 || bus.mm_start !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs got result=%h done=%b mm_start=%b want 0", bus.result, bus.done, bus.mm_start);
        end
        checks++; if (bus.mm_a !== 16'd0 || bus.mm_b !== 16'd0 || bus.mm_m !== 16'd0) begin
            errors++; $display("FAIL rstmid_operands got a=%h b=%h m=%h want 0", bus.mm_a, bus.mm_b, bus.mm_m);
        end
    endtask

    task automatic test_after_abort();
        logic [15:0] m, xp, x, r, want;
        logic [7:0]  e;
        int np, nd;
        bit to;
        m = rand_mod(); xp = 16'($urandom_range(0, m - 1)); e = 8'($urandom);
        x = to_mont(xp, m); r = to_mont(16'd1, m); want = ref_exp(xp, e, m);
        run_op(x, e, m, r, np, nd, to);
        checks++; if (to) begin errors++; $display("FAIL post_timeout got no done want done"); end
        checks++; if (bus.result !== want) begin errors++; $display("FAIL post_result got %h want %h", bus.result, want); end
        checks++; if (np != 8 + $countones(e)) begin errors++; $display("FAIL post_pulses got %0d want %0d", np, 8 + $countones(e)); end
    endtask

    initial begin
        test_reset();
        test_e_zero();
        test_e_one();
        test_all_ones();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_after_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
